// File: rtl/colour_zone_counter.sv
// Streaming red-pixel classifier: forwards raw pixels or a binary mask through one
// output register and publishes per-frame red counts for NUM_ZONES vertical strips.
module colour_zone_counter #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int NUM_ZONES = 4,
    parameter int CNT_W     = 17
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic                       pix_sop,
    input  logic                       pix_eop,
    input  logic [11:0]                pix_data,
    input  logic [3:0]                 upper_thresh,
    input  logic [3:0]                 lower_thresh,
    input  logic                       mask_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [11:0]                out_data,
    output logic [NUM_ZONES*CNT_W-1:0] zone_count,
    output logic [CNT_W-1:0]           total_count,
    output logic [2:0]                 max_zone,
    output logic                       result_valid,
    output logic                       frame_error
);

    localparam int ZONE_W = IMG_W / NUM_ZONES;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int IW     = $clog2(NPIX + 1);
    localparam int SW     = $clog2(NUM_ZONES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_REDUCE} state_t;

    state_t                     state_q, state_d;
    logic [XW-1:0]              x_q, x_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]           acc_q [NUM_ZONES];
    logic [CNT_W-1:0]           acc_d [NUM_ZONES];
    logic [CNT_W-1:0]           tot_acc_q, tot_acc_d;
    logic [SW-1:0]              scan_q, scan_d;
    logic [CNT_W-1:0]           best_q, best_d;
    logic [2:0]                 best_idx_q, best_idx_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_sop_q, out_sop_d;
    logic                       out_eop_q, out_eop_d;
    logic [11:0]                out_data_q, out_data_d;
    logic [NUM_ZONES*CNT_W-1:0] zone_count_q, zone_count_d;
    logic [CNT_W-1:0]           total_count_q, total_count_d;
    logic [2:0]                 max_zone_q, max_zone_d;
    logic                       result_valid_q, result_valid_d;
    logic                       frame_error_q, frame_error_d;

    logic                       accept;
    logic                       is_red;
    logic [11:0]                fwd_data;
    logic [XW-1:0]              cur_x;
    logic [IW-1:0]              cur_idx;
    logic [CNT_W-1:0]           cand;
    int                         zone_sel;

    // Gated by reset_n directly so the source sees no ready while reset is held.
    assign pix_ready = reset_n && (state_q != S_REDUCE) && (out_ready || !out_valid_q);
    assign accept    = pix_valid && pix_ready;
    assign is_red    = (pix_data[11:8] >= upper_thresh) && (pix_data[7:4] < lower_thresh)
                    && (pix_data[3:0] < lower_thresh);
    assign fwd_data  = mask_mode ? (is_red ? 12'hFFF : 12'h000) : pix_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d        = state_q;
        x_d            = x_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        tot_acc_d      = tot_acc_q;
        scan_d         = scan_q;
        best_d         = best_q;
        best_idx_d     = best_idx_q;
        out_valid_d    = out_ready ? 1'b0 : out_valid_q;
        out_sop_d      = out_sop_q;
        out_eop_d      = out_eop_q;
        out_data_d     = out_data_q;
        zone_count_d   = zone_count_q;
        total_count_d  = total_count_q;
        max_zone_d     = max_zone_q;
        result_valid_d = 1'b0;
        frame_error_d  = 1'b0;

        cur_x   = pix_sop ? '0 : x_q;
        cur_idx = pix_sop ? '0 : idx_q;
        zone_sel = 0;
        for (int z = 1; z < NUM_ZONES; z++) begin
            if (cur_x >= XW'(z * ZONE_W)) zone_sel = z;
        end
        cand = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            if (scan_q == SW'(z)) cand = acc_q[z];
        end

        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (accept && (state_q == S_ACTIVE || pix_sop)) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = pix_sop;
                    out_eop_d   = pix_eop;
                    out_data_d  = fwd_data;
                    if (pix_sop) begin
                        for (int z = 0; z < NUM_ZONES; z++) acc_d[z] = '0;
                        tot_acc_d = '0;
                    end
                    for (int z = 0; z < NUM_ZONES; z++) begin
                        if (is_red && zone_sel == z && acc_d[z] != '1) acc_d[z] = acc_d[z] + 1'b1;
                    end
                    if (is_red && tot_acc_d != '1) tot_acc_d = tot_acc_d + 1'b1;
                    if (state_q == S_ACTIVE && pix_sop) frame_error_d = 1'b1;

                    if (cur_idx > LAST_IDX || (pix_eop && cur_idx != LAST_IDX)) begin
                        // Malformed frame: drop the partial counts, keep published results.
                        frame_error_d = 1'b1;
                        state_d       = S_IDLE;
                        x_d           = '0;
                        idx_d         = '0;
                        for (int z = 0; z < NUM_ZONES; z++) acc_d[z] = '0;
                        tot_acc_d     = '0;
                    end else if (pix_eop) begin
                        state_d = S_REDUCE;
                        scan_d  = '0;
                        x_d     = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_ACTIVE;
                        idx_d   = cur_idx + 1'b1;
                        x_d     = (cur_x == XW'(IMG_W - 1)) ? '0 : cur_x + 1'b1;
                    end
                end
            end
            S_REDUCE: begin
                if (scan_q < SW'(NUM_ZONES)) begin
                    // Strict > keeps the lowest index on ties.
                    if (scan_q == '0 || cand > best_q) begin
                        best_d     = cand;
                        best_idx_d = 3'(scan_q);
                    end
                    scan_d = scan_q + 1'b1;
                end else begin
                    for (int z = 0; z < NUM_ZONES; z++) zone_count_d[z*CNT_W +: CNT_W] = acc_q[z];
                    total_count_d  = tot_acc_q;
                    max_zone_d     = best_idx_q;
                    result_valid_d = 1'b1;
                    for (int z = 0; z < NUM_ZONES; z++) acc_d[z] = '0;
                    tot_acc_d      = '0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            x_q            <= '0;
            idx_q          <= '0;
            for (int z = 0; z < NUM_ZONES; z++) acc_q[z] <= '0;
            tot_acc_q      <= '0;
            scan_q         <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            out_valid_q    <= 1'b0;
            out_sop_q      <= 1'b0;
            out_eop_q      <= 1'b0;
            out_data_q     <= '0;
            zone_count_q   <= '0;
            total_count_q  <= '0;
            max_zone_q     <= '0;
            result_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q        <= state_d;
            x_q            <= x_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            tot_acc_q      <= tot_acc_d;
            scan_q         <= scan_d;
            best_q         <= best_d;
            best_idx_q     <= best_idx_d;
            out_valid_q    <= out_valid_d;
            out_sop_q      <= out_sop_d;
            out_eop_q      <= out_eop_d;
            out_data_q     <= out_data_d;
            zone_count_q   <= zone_count_d;
            total_count_q  <= total_count_d;
            max_zone_q     <= max_zone_d;
            result_valid_q <= result_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign out_data     = out_data_q;
    assign zone_count   = zone_count_q;
    assign total_count  = total_count_q;
    assign max_zone     = max_zone_q;
    assign result_valid = result_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_colour_zone_counter.sv
// Directed bench for colour_zone_counter on an 8x2 image with four 2-pixel zones.
module tb_colour_zone_counter;

    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int NZ    = 4;
    localparam int CW    = 17;

    typedef struct {
        logic [11:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic           pix_sop = 1'b0;
    logic           pix_eop = 1'b0;
    logic [11:0]    pix_data = '0;
    logic [3:0]     upper_thresh = 4'd8;
    logic [3:0]     lower_thresh = 4'd4;
    logic           mask_mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_sop;
    logic           out_eop;
    logic [11:0]    out_data;
    logic [NZ*CW-1:0] zone_count;
    logic [CW-1:0]  total_count;
    logic [2:0]     max_zone;
    logic           result_valid;
    logic           frame_error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rv_cnt   = 0;
    int fe_cnt   = 0;
    int eop_edge = 0;
    int rv_edge  = 0;
    int n_osop   = 0;
    int n_oeop   = 0;
    bit toggle_en = 1'b0;

    beat_t       beats[$];
    logic [11:0] exp_q[$];
    logic [11:0] out_q[$];

    colour_zone_counter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_ZONES(NZ), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sop(pix_sop), .pix_eop(pix_eop), .pix_data(pix_data),
        .upper_thresh(upper_thresh), .lower_thresh(lower_thresh), .mask_mode(mask_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
        .zone_count(zone_count), .total_count(total_count), .max_zone(max_zone),
        .result_valid(result_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 out_ready = ~out_ready;
        end
    end

    // Observe handshakes mid-cycle; anything seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            out_q.push_back(out_data);
            if (out_sop) n_osop++;
            if (out_eop) n_oeop++;
        end
        if (pix_valid && pix_ready && pix_eop) eop_edge = cyc + 1;
        if (result_valid) begin
            rv_cnt++;
            rv_edge = cyc;
        end
        if (frame_error) fe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit i of red_map is pixel (x = i % 8, y = i / 8); red pixels are F00, others 888.
    task automatic push_frame(input logic [15:0] red_map, input int len, input bit with_eop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = red_map[i] ? 12'hF00 : 12'h888;
            b.sop  = (i == 0);
            b.eop  = with_eop && (i == len - 1);
            beats.push_back(b);
            if (mask_mode) exp_q.push_back(red_map[i] ? 12'hFFF : 12'h000);
            else           exp_q.push_back(b.data);
        end
    endtask

    task automatic send_all();
        for (int i = 0; i < beats.size(); i++) begin
            bit accepted = 1'b0;
            int waited   = 0;
            pix_valid = 1'b1;
            pix_data  = beats[i].data;
            pix_sop   = beats[i].sop;
            pix_eop   = beats[i].eop;
            while (!accepted && waited < 50) begin
                @(negedge clk);
                accepted = pix_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        end
        pix_valid = 1'b0;
        pix_sop   = 1'b0;
        pix_eop   = 1'b0;
        beats.delete();
    endtask

    task automatic start_test();
        out_q.delete();
        exp_q.delete();
        n_osop = 0;
        n_oeop = 0;
    endtask

    task automatic check_results(input string tag, input int z0, input int z1, input int z2,
                                 input int z3, input int tot, input int mz);
        check({tag, "_zone0"}, 32'(zone_count[0*CW +: CW]), z0);
        check({tag, "_zone1"}, 32'(zone_count[1*CW +: CW]), z1);
        check({tag, "_zone2"}, 32'(zone_count[2*CW +: CW]), z2);
        check({tag, "_zone3"}, 32'(zone_count[3*CW +: CW]), z3);
        check({tag, "_total"}, 32'(total_count), tot);
        check({tag, "_max_zone"}, 32'(max_zone), mz);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_beats"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
        check({tag, "_sop_count"}, n_osop, 1);
        check({tag, "_eop_count"}, n_oeop, 1);
    endtask

    initial begin
        int rv0;
        int fe0;

        // Reset state
        idle(3);
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        check_results("rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_pix_ready", 32'(pix_ready), 1);
        idle(1);

        // All-red frame, raw forwarding
        start_test();
        rv0 = rv_cnt; fe0 = fe_cnt;
        mask_mode = 1'b0;
        push_frame(16'hFFFF, 16, 1'b1);
        send_all();
        idle(12);
        check_results("all_red", 4, 4, 4, 4, 16, 0);
        check("all_red_rv", rv_cnt - rv0, 1);
        check("all_red_fe", fe_cnt - fe0, 0);
        check("all_red_latency", rv_edge - eop_edge, 5);
        check_stream("all_red");

        // Red only at x=6,7, mask forwarding
        start_test();
        rv0 = rv_cnt;
        mask_mode = 1'b1;
        push_frame(16'hC0C0, 16, 1'b1);
        send_all();
        idle(12);
        check_results("zone3", 0, 0, 0, 4, 4, 3);
        check("zone3_rv", rv_cnt - rv0, 1);
        check_stream("zone3_mask");

        // Same frame, raw forwarding, out_ready toggling every cycle
        start_test();
        rv0 = rv_cnt;
        mask_mode = 1'b0;
        push_frame(16'hC0C0, 16, 1'b1);
        toggle_en = 1'b1;
        send_all();
        idle(20);
        toggle_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        idle(4);
        check_results("toggle", 0, 0, 0, 4, 4, 3);
        check("toggle_rv", rv_cnt - rv0, 1);
        check_stream("toggle");

        // Early eop on beat 10, then a good frame
        start_test();
        rv0 = rv_cnt; fe0 = fe_cnt;
        push_frame(16'hFFFF, 10, 1'b1);
        send_all();
        idle(12);
        check("early_eop_fe", fe_cnt - fe0, 1);
        check("early_eop_rv", rv_cnt - rv0, 0);
        check_results("early_eop_hold", 0, 0, 0, 4, 4, 3);
        rv0 = rv_cnt; fe0 = fe_cnt;
        push_frame(16'h010C, 16, 1'b1);
        send_all();
        idle(12);
        check("after_err_rv", rv_cnt - rv0, 1);
        check("after_err_fe", fe_cnt - fe0, 0);
        check_results("after_err", 1, 2, 0, 0, 3, 1);

        // sop re-asserted at beat 5, followed by a full frame
        start_test();
        rv0 = rv_cnt; fe0 = fe_cnt;
        push_frame(16'hFFFF, 4, 1'b0);
        push_frame(16'h3010, 16, 1'b1);
        send_all();
        idle(12);
        check("resop_fe", fe_cnt - fe0, 1);
        check("resop_rv", rv_cnt - rv0, 1);
        check_results("resop", 0, 0, 3, 0, 3, 2);

        // Reset mid-frame at beat 8, then a good frame
        start_test();
        rv0 = rv_cnt;
        push_frame(16'hFFFF, 8, 1'b0);
        send_all();
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_pix_ready", 32'(pix_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        idle(2);
        reset_n = 1'b1;
        idle(12);
        check("midrst_rv", rv_cnt - rv0, 0);
        check("midrst_total", 32'(total_count), 0);
        rv0 = rv_cnt;
        push_frame(16'hFCFC, 16, 1'b1);
        send_all();
        idle(12);
        check("post_rst_rv", rv_cnt - rv0, 1);
        check_results("post_rst", 0, 4, 4, 4, 12, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
